// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data share one memory port,
// one transaction outstanding, with starvation protection for fetch and fetch flush.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            if_flush,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [2:0]      d_width,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_width,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic       owner;
    logic       drop;
    logic [2:0] starve_cnt;
    logic       sel_data;
    logic       resp;

    // Data normally wins; fetch takes over once it has lost STARVE_MAX grants in a row.
    assign sel_data = (d_req && (starve_cnt < 3'(STARVE_MAX))) || !if_req;

    assign mem_req   = rst_n && (state == IDLE) && (if_req || d_req);
    assign if_gnt    = mem_req && mem_ready && !sel_data;
    assign d_gnt     = mem_req && mem_ready && sel_data;

    assign mem_we    = rst_n && sel_data && d_we;
    assign mem_addr  = !rst_n ? '0 : (sel_data ? d_addr : if_addr);
    assign mem_wdata = (rst_n && sel_data) ? d_wdata : '0;
    assign mem_width = !rst_n ? 3'b000 : (sel_data ? d_width : 3'b010);

    // A response only counts while a transaction is outstanding; a flush in the
    // same cycle as a fetch response still swallows it.
    assign resp      = rst_n && (state == WAIT) && mem_rvalid;
    assign if_rvalid = resp && !owner && !drop && !if_flush;
    assign d_rvalid  = resp && owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    // Transaction tracking, starvation counter and fetch drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            drop       <= 1'b0;
            starve_cnt <= 3'd0;
        end else begin
            if (!if_req || if_gnt) begin
                starve_cnt <= 3'd0;
            end else if (d_gnt && (starve_cnt < 3'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (if_gnt || d_gnt) begin
                        state <= WAIT;
                        owner <= d_gnt;
                        drop  <= if_gnt && if_flush;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (!owner && if_flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
